// File: rtl/ysyx_22040237_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040237_regfile_sb
// Description : Multi-port register file with a busy-bit scoreboard and
//               optional same-cycle write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040237_regfile_sb #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NRD-1:0]         rd_en_i,
    input  logic [NRD*AW-1:0]      rd_idx_i,
    output logic [NRD*XLEN-1:0]    rd_data_o,
    output logic [NRD-1:0]         rd_busy_o,
    input  logic [NWR-1:0]         wr_en_i,
    input  logic [NWR*AW-1:0]      wr_idx_i,
    input  logic [NWR*XLEN-1:0]    wr_data_i,
    input  logic                   iss_valid_i,
    input  logic [AW-1:0]          iss_idx_i,
    input  logic                   flush_i,
    input  logic [63:0]            pc_i,
    output logic [NREG*XLEN+63:0]  dbg_o
);

    localparam logic [AW-1:0] c_ZERO_IDX = '0;

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // Later write ports overwrite earlier ones, so the highest port wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en_i[j] && (wr_idx_i[j*AW +: AW] != c_ZERO_IDX)) begin
                    r_regs[wr_idx_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
                end
            end
            r_busy <= w_busy_nxt;
        end
    end

    // Issue is applied after write-back clears so a newer producer keeps the bit.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j]) begin
                w_busy_nxt[wr_idx_i[j*AW +: AW]] = 1'b0;
            end
        end
        if (flush_i) begin
            w_busy_nxt = '0;
        end else if (iss_valid_i) begin
            w_busy_nxt[iss_idx_i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_ridx;
        logic [XLEN-1:0] w_data;
        logic            w_hit;

        assign w_ridx = rd_idx_i[k*AW +: AW];

        always_comb begin
            w_data = r_regs[w_ridx];
            w_hit  = 1'b0;
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en_i[j] && (wr_idx_i[j*AW +: AW] == w_ridx)) begin
                        w_hit  = 1'b1;
                        w_data = wr_data_i[j*XLEN +: XLEN];
                    end
                end
            end
            if (w_ridx == c_ZERO_IDX) begin
                w_hit  = 1'b0;
                w_data = '0;
            end
        end

        assign rd_data_o[k*XLEN +: XLEN] = (rst_n && rd_en_i[k]) ? w_data : '0;
        assign rd_busy_o[k] = rst_n & rd_en_i[k] & r_busy[w_ridx] & ~w_hit;
    end

    for (genvar i = 0; i < NREG; i++) begin : g_dbg
        assign dbg_o[i*XLEN +: XLEN] = r_regs[i];
    end
    assign dbg_o[NREG*XLEN +: 64] = pc_i;

endmodule
`default_nettype wire

// File: doc/ysyx_22040237_regfile_sb.md
YSYX_22040237_REGFILE_SB -- requirements
Module: ysyx_22040237_regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 64, register data width.
REQ-002 SHALL have parameter NREG, default 32, register count (power of 2, >=2); AW = $clog2(NREG).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding enabled.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-007 SHALL have ports: rd_en_i  in  NRD  per-read-port enable; rd_idx_i  in  NRD*AW  read indices, port k at [k*AW +: AW].
REQ-008 SHALL have ports: rd_data_o  out  NRD*XLEN  read data; rd_busy_o  out  NRD  source pending (consumer must stall).
REQ-009 SHALL have ports: wr_en_i  in  NWR  write enables; wr_idx_i  in  NWR*AW  write indices; wr_data_i  in  NWR*XLEN  write data.
REQ-010 SHALL have ports: iss_valid_i  in  1  producer issue; iss_idx_i  in  AW  destination being reserved; flush_i  in  1  clear all reservations.
REQ-011 SHALL have ports: pc_i  in  64  current pc; dbg_o  out  (NREG*XLEN)+64  snapshot {pc_i, regs[NREG-1..0]} for simulation.

Function
REQ-012 SHALL hold NREG x XLEN storage plus an NREG-bit busy vector, all state updated on rising clk.
REQ-013 SHALL hard-wire register 0: writes ignored, reads return 0, busy[0] never set.
REQ-014 SHALL read combinationally (0-cycle): rd_data_o[k] = regs[rd_idx k] when rd_en_i[k]=1, else 0.
REQ-015 SHALL, when BYPASS=1 and any wr_en_i[j] targets the nonzero read index in the same cycle, return that write data instead of stored value.
REQ-016 SHALL, with multiple same-cycle writes to one index, give priority to the highest write-port number, for both storage and bypass.
REQ-017 SHALL write wr_data_i[j] to regs[wr_idx j] at the clock edge when wr_en_i[j]=1 and wr_idx j != 0.
REQ-018 SHALL set busy[iss_idx_i] at the edge when iss_valid_i=1, flush_i=0, iss_idx_i != 0.
REQ-019 SHALL clear busy[i] at the edge when any write port writes index i, unless REQ-018 sets the same index that cycle (set wins: newer producer).
REQ-020 SHALL clear all busy bits at the edge when flush_i=1; same-cycle issue discarded; same-cycle writes still update storage.
REQ-021 SHALL drive rd_busy_o[k] = rd_en_i[k] & busy[idx k] & ~(BYPASS & same-cycle write to idx k); 0 for idx 0.
REQ-022 SHALL drive dbg_o combinationally from current storage (no bypass) and pc_i.
REQ-023 SHALL treat rd_idx/wr_idx/iss_idx as exact indices; no wrap or out-of-range case exists for power-of-2 NREG.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force all registers to 0 and all busy bits to 0, including mid-operation.
REQ-025 SHALL ignore writes and issues on any edge where rst_n=0; rd_data_o and rd_busy_o read 0 during reset.

Verification
REQ-026 Reset: write regs[5]=0xAA, set busy[5], assert rst_n=0 between edges -> regs[5]=0 and rd_busy_o=0 immediately, without a clock.
REQ-027 Write/read: wr port0 idx 3 data 0x1234 -> next cycle rd port1 idx3 = 0x1234; write idx 0 data 0xFF -> read idx0 = 0.
REQ-028 Bypass: BYPASS=1, same cycle wr port0 idx7=0x11, port1 idx7=0x22, read idx7 -> rd_data 0x22, stored 0x22; BYPASS=0 -> old value read, 0x22 stored.
REQ-029 Scoreboard: issue idx9 -> next cycle rd_busy=1 on idx9; write idx9 -> same cycle rd_busy=0 (BYPASS=1), busy cleared after edge.
REQ-030 Set-wins: busy[4]=1, same cycle issue idx4 and write idx4 -> busy[4] stays 1, regs[4] updated.
REQ-031 Flush: busy[2],busy[6]=1, flush_i with issue idx8 and write idx2=0x5 -> all busy 0, regs[2]=0x5, busy[8]=0.
